// File: rtl/mem_port_ctrl_if.sv
// RAM-side handshake bundle for mem_port_ctrl.
// The controller drives request/address/write data. The RAM returns read data and ack.
interface mem_port_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // Controller side.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    // RAM side.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory-side controller for the MAR/MDR pair.
// It runs one read or write at a time against a synchronous RAM, using an ack handshake
// with a bounded wait. Every output comes straight from a flop. The registered status
// outputs are decoded from the next state, so they line up with the state register.
module mem_port_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  rd_start,
    input  logic                  wr_start,
    output logic [31:0]           MDR,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    mem_port_ctrl_if.master       mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter value on the last wait cycle allowed before giving up.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              we_q, we_d;

    // Next-state, register-load and registered-output decode.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                // Bus loads only while idle, so the RAM sees stable MAR/MDR.
                if (MARin) begin
                    mar_d = BusMuxOut[ADDR_W-1:0];
                end
                if (MDRin) begin
                    mdr_d = BusMuxOut;
                end
                // A read wins over a simultaneous write.
                if (rd_start) begin
                    state_d = RD_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else if (wr_start) begin
                    state_d = WR_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end

            RD_WAIT, WR_WAIT: begin
                // Ack beats a timeout that expires in the same cycle.
                if (mem.mem_ack) begin
                    if (state_q == RD_WAIT) begin
                        mdr_d = mem.mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WAIT_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        req_d  = (state_d == RD_WAIT) || (state_d == WR_WAIT);
        we_d   = (state_d == WR_WAIT);
    end

    // State and datapath registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    assign MDR           = mdr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl.
// Each transaction pushes its expected latency, err flag and final MDR value onto a queue.
// The matching entry is popped and compared when done is seen.
module tb_mem_port_ctrl;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, rd_start, wr_start;
    logic [31:0] MDR;
    logic        busy, done, err;

    mem_port_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    mem_port_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .clear     (clear),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .MDR       (MDR),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (mif)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] mdr;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       mdr_model;
    logic [ADDR_W-1:0] mar_model;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_mar(input logic [31:0] v);
        BusMuxOut = v;
        MARin     = 1'b1;
        tick();
        MARin     = 1'b0;
        mar_model = v[ADDR_W-1:0];
        check_eq("mar_load", 32'(mif.mem_addr), 32'(mar_model));
        $display("load MAR  bus=0x%08h addr=0x%03h", v, mif.mem_addr);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        BusMuxOut = v;
        MDRin     = 1'b1;
        tick();
        MDRin     = 1'b0;
        mdr_model = v;
        check_eq("mdr_load", MDR, mdr_model);
        check_eq("mem_wdata_load", mif.mem_wdata, mdr_model);
        $display("load MDR  bus=0x%08h", v);
    endtask

    // ack_delay < 0 means the RAM never acks; poke drives the blocked inputs during the wait.
    task automatic run_txn(input bit do_rd, input bit do_wr, input int ack_delay,
                           input logic [31:0] rdata, input bit poke);
        exp_t        e;
        exp_t        got;
        bit          is_rd;
        bit          acked;
        bit          seen;
        int          lat;
        logic [31:0] mdr_before;

        is_rd      = do_rd;
        acked      = (ack_delay >= 0) && (ack_delay <= TIMEOUT - 1);
        mdr_before = mdr_model;
        e.lat      = acked ? ack_delay + 2 : TIMEOUT + 1;
        e.err      = !acked;
        e.mdr      = (is_rd && acked) ? rdata : mdr_model;
        exp_q.push_back(e);
        mdr_model  = e.mdr;
        seen       = 1'b0;
        lat        = 0;

        rd_start = do_rd;
        wr_start = do_wr;
        tick();
        rd_start = 1'b0;
        wr_start = 1'b0;

        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            check_eq("mem_req_wait", 32'(mif.mem_req), 32'd1);
            check_eq("mem_we_wait", 32'(mif.mem_we), 32'(!is_rd));
            check_eq("err_wait", 32'(err), 32'd0);
            check_eq("mem_addr_wait", 32'(mif.mem_addr), 32'(mar_model));
            check_eq("mem_wdata_wait", mif.mem_wdata, mdr_before);
            if (poke && k == 1) begin
                BusMuxOut = 32'h1234_5678;
                MARin     = 1'b1;
                MDRin     = 1'b1;
                rd_start  = 1'b1;
                wr_start  = 1'b1;
            end
            if (ack_delay >= 0 && k == ack_delay + 1) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdata;
            end else begin
                mif.mem_ack   = 1'b0;
                mif.mem_rdata = $urandom;
            end
            tick();
            MARin       = 1'b0;
            MDRin       = 1'b0;
            rd_start    = 1'b0;
            wr_start    = 1'b0;
            mif.mem_ack = 1'b0;
            if (done) begin
                lat  = k + 1;
                seen = 1'b1;
                break;
            end
        end

        check_eq("done_seen", 32'(seen), 32'd1);
        got = exp_q.pop_front();
        if (seen) begin
            check_eq("latency", 32'(lat), 32'(got.lat));
            check_eq("err_done", 32'(err), 32'(got.err));
            check_eq("mdr_done", MDR, got.mdr);
            check_eq("busy_done", 32'(busy), 32'd1);
            check_eq("mem_req_done", 32'(mif.mem_req), 32'd0);
            check_eq("mem_addr_done", 32'(mif.mem_addr), 32'(mar_model));
            $display("txn %s delay=%0d lat=%0d err=%0b MDR=0x%08h",
                     is_rd ? "RD" : "WR", ack_delay, lat, err, MDR);
            tick();
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("busy_idle", 32'(busy), 32'd0);
            check_eq("err_held", 32'(err), 32'(got.err));
        end else begin
            $display("txn %s delay=%0d no done within budget", is_rd ? "RD" : "WR", ack_delay);
            clear = 1'b1;
            tick();
            clear     = 1'b0;
            mdr_model = 32'd0;
            mar_model = '0;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_req"}, 32'(mif.mem_req), 32'd0);
        check_eq({tag, "_we"}, 32'(mif.mem_we), 32'd0);
        check_eq({tag, "_mdr"}, MDR, 32'd0);
        check_eq({tag, "_addr"}, 32'(mif.mem_addr), 32'd0);
    endtask

    initial begin
        clear         = 1'b1;
        BusMuxOut     = 32'd0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        rd_start      = 1'b0;
        wr_start      = 1'b0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        mdr_model     = 32'd0;
        mar_model     = '0;

        tick();
        tick();
        clear = 1'b0;
        check_idle_zero("reset");
        $display("reset released");

        // Read with zero wait states.
        load_mar(32'h0000_0012);
        run_txn(1'b1, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);

        // Write with three wait cycles.
        load_mar(32'h0000_01FF);
        load_mdr(32'hA5A5_5A5A);
        run_txn(1'b0, 1'b1, 3, 32'h0, 1'b0);

        // Timeout, then a start that clears err, with the ack on the final wait cycle.
        run_txn(1'b1, 1'b0, -1, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);

        // Simultaneous starts: the read wins.
        load_mar(32'h0000_0055);
        run_txn(1'b1, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

        // Blocked inputs during RD_WAIT.
        run_txn(1'b1, 1'b0, 2, 32'h1357_9BDF, 1'b1);

        // Stray ack in IDLE.
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stray_done", 32'(done), 32'd0);
            check_eq("stray_busy", 32'(busy), 32'd0);
            check_eq("stray_req", 32'(mif.mem_req), 32'd0);
            check_eq("stray_mdr", MDR, mdr_model);
        end
        mif.mem_ack = 1'b0;
        $display("stray ack in IDLE ignored MDR=0x%08h", MDR);

        // Clear in the middle of RD_WAIT.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        check_eq("pre_clear_busy", 32'(busy), 32'd1);
        check_eq("pre_clear_req", 32'(mif.mem_req), 32'd1);
        clear = 1'b1;
        tick();
        check_eq("clear_req_drop", 32'(mif.mem_req), 32'd0);
        tick();
        clear     = 1'b0;
        mdr_model = 32'd0;
        mar_model = '0;
        check_idle_zero("midclear");
        $display("clear during RD_WAIT");

        // The controller is back in IDLE and accepts a new read.
        run_txn(1'b1, 1'b0, 0, 32'h0000_55AA, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory-side controller for the datapath's MAR/MDR pair. It captures addresses and write data from the bus mux output and runs read/write transactions against a synchronous RAM with an ack handshake and timeout. It returns the read data through the MDR register, which drives the bus mux `MDR` input. One transaction is outstanding at a time, and the control sequencer waits on `done` before continuing.

## Interface
Parameters:
- `ADDR_W`, default 9: MAR width; the RAM address is `BusMuxOut[ADDR_W-1:0]`.
- `TIMEOUT`, default 15: maximum number of wait cycles without ack before the transaction aborts (range 1..255).

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `clear`, in, 1: reset, synchronous, active-high.
- `BusMuxOut`, in, 32: bus value from the bus mux.
- `MARin`, in, 1: load MAR from the bus.
- `MDRin`, in, 1: load MDR from the bus.
- `rd_start`, in, 1: one-cycle pulse that starts a read at the address in MAR.
- `wr_start`, in, 1: one-cycle pulse that starts a write of MDR to the address in MAR.
- `MDR`, out, 32: MDR register contents; feeds the bus mux.
- `busy`, out, 1: high in states RD_WAIT, WR_WAIT and DONE.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: set when a transaction times out; held until the next start.
- `mem_req`, out, 1: registered request to the RAM.
- `mem_we`, out, 1: registered write enable; meaningful only while `mem_req` is high.
- `mem_addr`, out, ADDR_W: equals MAR.
- `mem_wdata`, out, 32: equals MDR.
- `mem_rdata`, in, 32: RAM read data; valid in the cycle `mem_ack` is high.
- `mem_ack`, in, 1: RAM completion; sampled only in the wait states.

## Operation
- The FSM has four states: IDLE, RD_WAIT, WR_WAIT and DONE. All outputs are registered or taken directly from registers.
- **IDLE:**
  - `MARin` loads MAR.
  - `MDRin` loads MDR.
  - If both `MARin` and `MDRin` are high, both registers load the same bus value.
  - `rd_start` moves to RD_WAIT. `wr_start` moves to WR_WAIT.
  - If `rd_start` and `wr_start` are high together, the read wins and the write is dropped.
  - A start clears `err` and the wait counter.
- **RD_WAIT / WR_WAIT:**
  - `mem_req` = 1. `mem_we` = 0 in RD_WAIT and 1 in WR_WAIT.
  - `MARin`, `MDRin`, `rd_start` and `wr_start` are ignored, so MAR and MDR stay stable for the RAM.
  - On a cycle with `mem_ack` = 1:
    - In RD_WAIT, MDR loads `mem_rdata`.
    - The FSM moves to DONE.
  - Otherwise the 8-bit wait counter increments. The cycle in which it equals TIMEOUT-1 moves the FSM to DONE with `err` set and MDR unchanged.
  - `mem_ack` in that same cycle takes priority over the timeout, so the transaction completes normally.
- **DONE:**
  - `done` = 1 and `mem_req` = 0.
  - All inputs are ignored.
  - The FSM always returns to IDLE next cycle.
- `mem_ack` outside the wait states is ignored.
- `clear` has priority over everything, including mid-transaction.

## Timing
- Reset values:
  - State = IDLE.
  - MAR, MDR and the counter = 0.
  - `busy`, `done`, `err`, `mem_req` and `mem_we` = 0.
- Start at edge E puts the FSM in the wait state after E, so `mem_req` is high from E+1.
- If `mem_ack` is sampled high at edge E+1 (zero wait states), `done` is high during the cycle after E+1 and read data is visible on MDR in that same cycle. Minimum latency from start pulse to `done` is 2 cycles.
- Each additional wait cycle adds 1 cycle of latency.
- A timeout produces `done` and `err` TIMEOUT+1 cycles after the start edge.
- The earliest next start is accepted at the edge that leaves DONE, i.e. while back in IDLE.
- `clear` asserted while `mem_req` is high drops `mem_req` at the next edge. The RAM must tolerate an abandoned request.

## Test plan
- **Reset:** assert `clear` for 2 cycles mid-RD_WAIT -> all outputs 0, state IDLE, MDR = 0.
- **Read, zero wait:**
  - `BusMuxOut` = 0x0000_0012 with `MARin`.
  - `rd_start` with RAM returning 0xDEAD_BEEF and ack on the first request cycle.
  - Required: `mem_addr` = 0x012, `done` 2 cycles after start, MDR = 0xDEAD_BEEF.
- **Write, 3 wait cycles:**
  - MAR = 0x1FF, `MDRin` with 0xA5A5_5A5A.
  - `wr_start`, ack delayed 3 cycles.
  - Required: `mem_we` = 1, `mem_wdata` = 0xA5A5_5A5A throughout, `done` 5 cycles after start, `err` = 0.
- **Timeout:**
  - `rd_start` with no ack, TIMEOUT = 15.
  - Required: `done` and `err` at 16 cycles, MDR unchanged.
  - A following start clears `err`.
  - Ack arriving on the final wait cycle completes normally with `err` = 0.
- **Simultaneous and blocked inputs:**
  - `rd_start` with `wr_start` -> read performed, `mem_we` = 0.
  - `MARin`/`MDRin`/start during RD_WAIT -> MAR, MDR and transaction unaffected.
- **Stray ack:** `mem_ack` = 1 in IDLE -> no state change, no `done`.
